serial_byte_receiver: RTL and testbench
=======================================

SERIAL_BYTE_RECEIVER -- requirements
Module: serial_byte_receiver

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per frame (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, 1 = first received bit lands in Q[WIDTH-1], 0 = first bit lands in Q[0].
REQ-003 Clock  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Inhibit  input  1  active-high; when 1, the current edge is ignored (no sample, no count, no state change).
REQ-006 Start  input  1  marks that DS carries the first bit of a new frame this cycle.
REQ-007 DS  input  1  serial data, sampled on each non-inhibited rising edge.
REQ-008 Q  output  WIDTH  parallel word of the last completed frame, registered.
REQ-009 Valid  output  1  single-cycle pulse, Q updated with a new frame.
REQ-010 Busy  output  1  high while a frame is partially received.
REQ-011 FrameErr  output  1  single-cycle pulse, frame aborted by an early Start.

Function
REQ-012 FSM states IDLE and SHIFT; internal shift register sr[WIDTH-1:0]; bit counter cnt, width $clog2(WIDTH+1).
REQ-013 IDLE, Start=1, Inhibit=0: sample DS as bit 1, cnt<=1, go to SHIFT; otherwise remain in IDLE and ignore DS.
REQ-014 SHIFT, Start=0, Inhibit=0: shift DS into sr, cnt<=cnt+1.
REQ-015 MSB_FIRST=1: sr<={sr[WIDTH-2:0],DS}. MSB_FIRST=0: sr<={DS,sr[WIDTH-1:1]}.
REQ-016 Completion: the edge that samples bit WIDTH also loads Q with the complete word, sets Valid=1 for exactly one cycle, returns to IDLE, and clears cnt.
REQ-017 Latency: Q and Valid are visible in the cycle immediately after the edge that samples the final bit. There is no additional pipeline delay.
REQ-018 Back-to-back frames: Start in the first cycle after completion is accepted. The zero-gap stream is lossless.
REQ-019 SHIFT, Start=1, Inhibit=0: the partial frame is discarded and FrameErr pulses for one cycle. The DS bit on that edge becomes bit 1 of the new frame (cnt<=1, stay in SHIFT). Q and Valid are not affected.
REQ-020 Start=1 while Inhibit=1 is ignored in both states.
REQ-021 Inhibit=1 for any number of cycles mid-frame freezes sr, cnt and state. Reception resumes on the next non-inhibited edge. Valid is delayed by exactly the number of inhibited edges.
REQ-022 Q holds its value between frames and is never updated by a partial or aborted frame.
REQ-023 Busy = (state==SHIFT). Busy is registered-state derived and carries no combinational path from inputs.
REQ-024 Valid and FrameErr are never both 1 in the same cycle.

Reset
REQ-025 Reset=1 at a rising edge forces state=IDLE, sr=0, cnt=0, Q=0, Valid=0, Busy=0, FrameErr=0, regardless of Inhibit or Start.
REQ-026 Reset mid-frame discards the partial frame with no Valid and no FrameErr. The first edge after Reset deasserts behaves as IDLE.

Structure
REQ-027 Shared package serial_pkg holds the state enum (IDLE, SHIFT) and the constant DEFAULT_WIDTH=8. The companion parallel-load transmitter also uses this package.
REQ-028 Single flat module with no sub-modules. The shift register, counter and FSM are local always_ff blocks.
REQ-029 The RTL has no latches, no multi-driven signals, and no Inhibit-gated clocks; Inhibit acts as a clock enable only.

Verification
REQ-030 Reset, then Start with stream 1,0,1,0,0,0,0,1 (MSB_FIRST=1, WIDTH=8) -> Q=8'hA1, Valid high for one cycle after the 8th edge, Busy high for 7 cycles.
REQ-031 Same stream with MSB_FIRST=0 -> Q=8'h85, with identical Valid timing.
REQ-032 Stream 8'hA1 with Inhibit=1 for 3 cycles after bit 4 -> Q=8'hA1, Valid delayed exactly 3 cycles, DS toggled during Inhibit has no effect.
REQ-033 Start, 4 bits, then Start with 8'h3C -> FrameErr pulses once on the restart edge, then Q=8'h3C and Valid. Q holds its previous value until then.
REQ-034 Zero-gap frames 8'hA1 then 8'h5E -> two Valid pulses 8 cycles apart, Q=8'hA1 then Q=8'h5E.
REQ-035 Reset asserted after bit 5 of a frame -> all outputs 0 on the next cycle, no Valid. A following full frame 8'hFF gives Q=8'hFF.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver and its companion parallel-load transmitter.
package serial_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/serial_byte_receiver.sv
// Serial-to-parallel frame receiver: Start marks bit 1, WIDTH bits form a word on Q.
// Inhibit acts purely as a clock enable for all frame state.
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inhibit,
    input  logic             i_start,
    input  logic             i_ds,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_frame_err
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_d;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_sr_first;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_d;
    logic             r_valid;
    logic             w_valid_d;
    logic             r_frame_err;
    logic             w_frame_err_d;

    // Shifted word and fresh-frame word; the stale bits of w_sr_first are pushed out by completion.
    always_comb begin
        if (MSB_FIRST) begin
            w_sr_shift = {r_sr[WIDTH-2:0], i_ds};
            w_sr_first = {{(WIDTH-1){1'b0}}, i_ds};
        end else begin
            w_sr_shift = {i_ds, r_sr[WIDTH-1:1]};
            w_sr_first = {i_ds, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_sr_d        = r_sr;
        w_cnt_d       = r_cnt;
        w_q_d         = r_q;
        w_valid_d     = 1'b0;
        w_frame_err_d = 1'b0;
        if (!i_inhibit) begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_sr_d    = w_sr_first;
                        w_cnt_d   = ONE_CNT;
                        w_state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (i_start) begin
                        w_sr_d        = w_sr_first;
                        w_cnt_d       = ONE_CNT;
                        w_frame_err_d = 1'b1;
                    end else if (r_cnt == LAST_CNT) begin
                        w_sr_d    = w_sr_shift;
                        w_q_d     = w_sr_shift;
                        w_valid_d = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = IDLE;
                    end else begin
                        w_sr_d  = w_sr_shift;
                        w_cnt_d = r_cnt + ONE_CNT;
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_sr        <= w_sr_d;
            r_cnt       <= w_cnt_d;
            r_q         <= w_q_d;
            r_valid     <= w_valid_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    assign o_q         = r_q;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench: an MSB-first and an LSB-first receiver share one serial stream.
module tb_serial_byte_receiver;

    typedef struct {
        logic [7:0] qm;
        logic [7:0] ql;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       inhibit;
    logic       start;
    logic       ds;
    logic [7:0] q_m;
    logic [7:0] q_l;
    logic       valid_m, valid_l;
    logic       busy_m, busy_l;
    logic       ferr_m, ferr_l;

    exp_t       exp_q[$];
    int         ferr_q[$];
    int         cyc = 0;
    logic       rst_seen = 1'b1;
    logic       mon_on = 1'b0;
    logic [7:0] last_m = 8'h00;
    logic [7:0] last_l = 8'h00;
    int         n_tests = 0;
    int         n_fail = 0;

    serial_byte_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk(clk), .i_reset(reset), .i_inhibit(inhibit), .i_start(start), .i_ds(ds),
        .o_q(q_m), .o_valid(valid_m), .o_busy(busy_m), .o_frame_err(ferr_m)
    );

    serial_byte_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_reset(reset), .i_inhibit(inhibit), .i_start(start), .i_ds(ds),
        .o_q(q_l), .o_valid(valid_l), .o_busy(busy_l), .o_frame_err(ferr_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        rst_seen = reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents Valid or FrameErr.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_seen) begin
                check("reset_q_m", {24'd0, q_m}, 32'd0);
                check("reset_q_l", {24'd0, q_l}, 32'd0);
                check("reset_flags", {valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l}, 32'd0);
                last_m = 8'h00;
                last_l = 8'h00;
            end else begin
                check("valid_agree", {31'd0, valid_l}, {31'd0, valid_m});
                check("ferr_agree", {31'd0, ferr_l}, {31'd0, ferr_m});
                check("valid_ferr_excl", {31'd0, valid_m & ferr_m}, 32'd0);
                if (valid_m) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("q_msb_first", {24'd0, q_m}, {24'd0, e.qm});
                        check("q_lsb_first", {24'd0, q_l}, {24'd0, e.ql});
                        check("valid_cycle", cyc, e.cyc);
                        last_m = e.qm;
                        last_l = e.ql;
                    end
                end else begin
                    check("q_hold_m", {24'd0, q_m}, {24'd0, last_m});
                    check("q_hold_l", {24'd0, q_l}, {24'd0, last_l});
                end
                if (ferr_m) begin
                    if (ferr_q.size() == 0) check("unexpected_ferr", 32'd1, 32'd0);
                    else check("ferr_cycle", cyc, ferr_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic s, input logic d, input logic inh);
        start   = s;
        ds      = d;
        inhibit = inh;
        @(posedge clk);
        #1;
    endtask

    task automatic check_busy(input string name, input logic req);
        check(name, {30'd0, busy_m, busy_l}, {30'd0, req, req});
    endtask

    // Sends a frame MSB-of-d first; n_inh inhibited edges are inserted before bit index inh_at.
    task automatic send_frame(input logic [7:0] d, input logic [7:0] exp_l,
                              input int inh_at, input int n_inh);
        exp_t e;
        e.qm  = d;
        e.ql  = exp_l;
        e.cyc = cyc + 8 + n_inh;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (i == inh_at) begin
                for (int k = 0; k < n_inh; k++) begin
                    step(k[0], ~d[7-i], 1'b1);
                    check_busy("busy_inhibit", 1'b1);
                end
            end
            step(i == 0, d[7-i], 1'b0);
            check_busy("busy_frame", i < 7);
        end
    endtask

    initial begin
        reset   = 1'b1;
        inhibit = 1'b1;
        start   = 1'b1;
        ds      = 1'b1;
        mon_on  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle: DS ignored, Start under Inhibit ignored.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_busy("busy_idle", 1'b0);

        // Basic frame; LSB-first receiver sees 8'h85.
        send_frame(8'hA1, 8'h85, 99, 0);
        step(1'b0, 1'b0, 1'b0);

        // Frame with 3 inhibited edges after bit 4.
        send_frame(8'hA1, 8'h85, 4, 3);
        step(1'b0, 1'b1, 1'b0);

        // Abort after 4 bits (1,1,1,1), then restart with 8'h3C.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        ferr_q.push_back(cyc + 1);
        send_frame(8'h3C, 8'h3C, 99, 0);
        step(1'b0, 1'b0, 1'b0);

        // Zero-gap frames.
        send_frame(8'hA1, 8'h85, 99, 0);
        send_frame(8'h5E, 8'h7A, 99, 0);
        step(1'b0, 1'b0, 1'b0);

        // Reset after bit 5 of 8'h5E: partial frame lost.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        send_frame(8'hFF, 8'hFF, 99, 0);

        repeat (12) step(1'b0, 1'b0, 1'b0);
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("ferr_queue_drained", ferr_q.size(), 32'd0);
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
